id_ex_stage: RTL and testbench

ID/EX pipeline register with hazard control for the MIPS pipeline. It sits directly downstream of the control unit and register file. Each cycle it captures the decoded EX/MEM/WB control bundles, the MULTU start strobe and the operand fields into the EX stage. It detects load-use and HI/LO-busy hazards, and inserts bubbles on stall or branch/jump flush. A built-in down-counter tracks the multi-cycle MULTU in flight.

---
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use / HI-LO hazard detection and MULTU busy tracking.
//   Parameters: DATA_W (operand/immediate/PC width), MULT_CYCLES (cycles MULTU occupies the multiplier, 1..63).
//   Inputs : clk, rst (synchronous, active-low), ex_in/mem_in/wb_in control bundles, mult_start_in,
//            id_opcode/id_funct/id_rs/id_rt/id_rd, rs_data/rt_data/imm_ext/pc_plus4, flush.
//   Outputs: ex_q/mem_q/wb_q/mult_start_q registered control, rs_q/rt_q/rd_q and data registers,
//            stall (combinational, holds PC and IF/ID), mult_busy (multiplier occupied).
module id_ex_stage #(
    parameter int DATA_W      = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ex_in,
    input  logic [2:0]        mem_in,
    input  logic [1:0]        wb_in,
    input  logic              mult_start_in,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              flush,
    output logic [3:0]        ex_q,
    output logic [2:0]        mem_q,
    output logic [1:0]        wb_q,
    output logic              mult_start_q,
    output logic [4:0]        rs_q,
    output logic [4:0]        rt_q,
    output logic [4:0]        rd_q,
    output logic [DATA_W-1:0] rs_data_q,
    output logic [DATA_W-1:0] rt_data_q,
    output logic [DATA_W-1:0] imm_q,
    output logic [DATA_W-1:0] pc_plus4_q,
    output logic              stall,
    output logic              mult_busy
);
    localparam int CW = $clog2(MULT_CYCLES + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        ex_d;
    logic [2:0]        mem_d;
    logic [1:0]        wb_d;
    logic              mult_start_d;
    logic [4:0]        rs_d, rt_d, rd_d;
    logic [DATA_W-1:0] rs_data_d, rt_data_d, imm_d, pc_plus4_d;
    logic              lu, hl, bubble;

    assign mult_busy = cnt_q != '0;
    // load in EX whose destination is read by the instruction in ID
    assign lu = mem_q[2] & (rt_q != 5'd0) & ((rt_q == id_rs) | (rt_q == id_rt));
    // MFHI, MFLO or another MULTU must wait for the multiplier
    assign hl = mult_busy & (id_opcode == 6'h00) &
                ((id_funct == 6'h10) | (id_funct == 6'h12) | (id_funct == 6'h19));
    // flush wins so the front end is free to fetch the branch target
    assign stall  = (lu | hl) & ~flush;
    assign bubble = flush | lu | hl;

    always_comb begin
        ex_d         = bubble ? 4'd0 : ex_in;
        mem_d        = bubble ? 3'd0 : mem_in;
        wb_d         = bubble ? 2'd0 : wb_in;
        mult_start_d = bubble ? 1'b0 : mult_start_in;
        rs_d         = id_rs;
        rt_d         = id_rt;
        rd_d         = id_rd;
        rs_data_d    = rs_data;
        rt_data_d    = rt_data;
        imm_d        = imm_ext;
        pc_plus4_d   = pc_plus4;
        // flush does not clear the counter: a MULTU already in EX completes
        cnt_d        = (mult_start_in & ~bubble) ? CW'(MULT_CYCLES) :
                       mult_busy ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            mult_start_q <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            pc_plus4_q   <= '0;
            cnt_q        <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            mult_start_q <= mult_start_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            pc_plus4_q   <= pc_plus4_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ex_in;
    logic [2:0]    mem_in;
    logic [1:0]    wb_in;
    logic          mult_start_in;
    logic [5:0]    id_opcode, id_funct;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] rs_data, rt_data, imm_ext, pc_plus4;
    logic          flush;
    logic [3:0]    ex_q;
    logic [2:0]    mem_q;
    logic [1:0]    wb_q;
    logic          mult_start_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q, pc_plus4_q;
    logic          stall, mult_busy;

    int vecs = 0;
    int errs = 0;
    int n;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .MULT_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
        .mult_start_in(mult_start_in), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .rs_data(rs_data), .rt_data(rt_data),
        .imm_ext(imm_ext), .pc_plus4(pc_plus4), .flush(flush), .ex_q(ex_q), .mem_q(mem_q),
        .wb_q(wb_q), .mult_start_q(mult_start_q), .rs_q(rs_q), .rt_q(rt_q), .rd_q(rd_q),
        .rs_data_q(rs_data_q), .rt_data_q(rt_data_q), .imm_q(imm_q), .pc_plus4_q(pc_plus4_q),
        .stall(stall), .mult_busy(mult_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [3:0] e, input logic [2:0] m, input logic [1:0] w,
                          input logic ms, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic fl);
        ex_in = e; mem_in = m; wb_in = w; mult_start_in = ms;
        id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ex_in = 4'($urandom); mem_in = 3'($urandom); wb_in = 2'($urandom);
        mult_start_in = 1'b1; id_opcode = 6'($urandom); id_funct = 6'h19;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        rs_data = $urandom; rt_data = $urandom; imm_ext = $urandom; pc_plus4 = $urandom;
        flush = 1'($urandom);
        step(); step();
        chk("rst_ex", 32'(ex_q), 0);
        chk("rst_mem", 32'(mem_q), 0);
        chk("rst_wb", 32'(wb_q), 0);
        chk("rst_ms", 32'(mult_start_q), 0);
        chk("rst_rs", 32'(rs_q), 0);
        chk("rst_rsd", rs_data_q, 0);
        chk("rst_pc", pc_plus4_q, 0);
        chk("rst_busy", 32'(mult_busy), 0);
        chk("rst_stall", 32'(stall), 0);

        // ADD after release
        rst = 1'b1;
        rs_data = 32'h1111_0001; rt_data = 32'h2222_0002; imm_ext = 32'h0000_0020; pc_plus4 = 32'h0040_0004;
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        step();
        chk("add_ex", 32'(ex_q), 32'hc);
        chk("add_wb", 32'(wb_q), 32'h2);
        chk("add_rd", 32'(rd_q), 3);
        chk("add_rsd", rs_data_q, 32'h1111_0001);
        chk("add_pc", pc_plus4_q, 32'h0040_0004);

        // LW $t0, then consumer reading $t0
        id_set(4'b0001, 3'b100, 2'b11, 1'b0, 6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0);
        step();
        chk("lw_mem", 32'(mem_q), 32'h4);
        chk("lw_rt", 32'(rt_q), 8);
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h20, 5'd8, 5'd4, 5'd5, 1'b0);
        chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_bub_ex", 32'(ex_q), 0);
        chk("lu_bub_mem", 32'(mem_q), 0);
        chk("lu_bub_wb", 32'(wb_q), 0);
        chk("lu_release", 32'(stall), 0);
        step();
        chk("lu_cap_ex", 32'(ex_q), 32'hc);
        chk("lu_cap_rd", 32'(rd_q), 5);

        // LW to $zero never stalls
        id_set(4'b0001, 3'b100, 2'b11, 1'b0, 6'h23, 6'h00, 5'd9, 5'd0, 5'd0, 1'b0);
        step();
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 1'b0);
        chk("lu0_stall", 32'(stall), 0);
        step();
        chk("lu0_wb", 32'(wb_q), 32'h2);
        chk("lu0_rd", 32'(rd_q), 6);

        // flush of BEQ
        id_set(4'b0010, 3'b001, 2'b00, 1'b0, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        chk("fl_stall", 32'(stall), 0);
        step();
        chk("fl_mem", 32'(mem_q), 0);
        chk("fl_wb", 32'(wb_q), 0);
        chk("fl_ex", 32'(ex_q), 0);

        // flush coinciding with load-use
        id_set(4'b0001, 3'b100, 2'b11, 1'b0, 6'h23, 6'h00, 5'd9, 5'd8, 5'd0, 1'b0);
        step();
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h20, 5'd8, 5'd4, 5'd5, 1'b1);
        chk("fllu_stall", 32'(stall), 0);
        step();
        chk("fllu_ex", 32'(ex_q), 0);
        chk("fllu_wb", 32'(wb_q), 0);

        // MULTU then MFLO: busy for 32 cycles after the capture edge
        id_set(4'b0100, 3'b000, 2'b00, 1'b1, 6'h00, 6'h19, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        chk("mul_start", 32'(mult_start_q), 1);
        chk("mul_busy", 32'(mult_busy), 1);
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h12, 5'd0, 5'd0, 5'd7, 1'b0);
        n = 0;
        while (stall && n < 40) begin
            n++;
            step();
            chk("mflo_bubble", 32'(wb_q), 0);
        end
        chk("mflo_stall_cycles", n, 32);
        chk("mflo_busy_low", 32'(mult_busy), 0);
        step();
        chk("mflo_cap_wb", 32'(wb_q), 32'h2);
        chk("mflo_cap_rd", 32'(rd_q), 7);

        // back-to-back MULTU stalls the second one the same way
        id_set(4'b0100, 3'b000, 2'b00, 1'b1, 6'h00, 6'h19, 5'd1, 5'd2, 5'd0, 1'b0);
        step();
        n = 0;
        while (stall && n < 40) begin
            n++;
            step();
            chk("mul2_bubble", 32'(mult_start_q), 0);
        end
        chk("mul2_stall_cycles", n, 32);
        step();
        chk("mul2_start", 32'(mult_start_q), 1);
        chk("mul2_busy", 32'(mult_busy), 1);

        // reset with 10 cycles left on the counter releases a pending MFLO
        id_set(4'b1100, 3'b000, 2'b10, 1'b0, 6'h00, 6'h12, 5'd0, 5'd0, 5'd9, 1'b0);
        repeat (22) step();
        chk("rmm_stall", 32'(stall), 1);
        rst = 1'b0;
        step();
        chk("rmm_busy", 32'(mult_busy), 0);
        chk("rmm_stall_rel", 32'(stall), 0);
        rst = 1'b1;
        step();
        chk("rmm_cap_wb", 32'(wb_q), 32'h2);
        chk("rmm_cap_rd", 32'(rd_q), 9);

        // unimplemented opcode: controls pass when not bubbled, zeroed under flush
        id_set(4'b1011, 3'b011, 2'b01, 1'b1, 6'h3f, 6'h3f, 5'd3, 5'd4, 5'd5, 1'b1);
        step();
        chk("unimp_fl_ex", 32'(ex_q), 0);
        chk("unimp_fl_mem", 32'(mem_q), 0);
        chk("unimp_fl_ms", 32'(mult_start_q), 0);
        chk("unimp_fl_busy", 32'(mult_busy), 0);
        id_set(4'b1011, 3'b011, 2'b01, 1'b0, 6'h3f, 6'h3f, 5'd3, 5'd4, 5'd5, 1'b0);
        step();
        chk("unimp_ex", 32'(ex_q), 32'hb);
        chk("unimp_mem", 32'(mem_q), 32'h3);
        chk("unimp_wb", 32'(wb_q), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
